// File: rtl/alu_seq_param_if.sv
// Handshake and data bundle between the operand sequencer, the sequential ALU and writeback.
// The master side drives operands and acknowledges; the slave side is the ALU.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             input_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] operand_A;
  logic [WIDTH-1:0] operand_B;
  logic             carry_in;
  logic             borrow_in;
  logic             result_ack;
  logic             busy;
  logic             result_ready;
  logic [WIDTH-1:0] y_out;
  logic             carry_out;
  logic             borrow_out;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             parity;
  logic             illegal_op;

  modport master (
    output enable, input_ready, opcode, operand_A, operand_B, carry_in, borrow_in, result_ack,
    input  busy, result_ready, y_out, carry_out, borrow_out, zero, negative, overflow, parity, illegal_op
  );

  modport slave (
    input  enable, input_ready, opcode, operand_A, operand_B, carry_in, borrow_in, result_ack,
    output busy, result_ready, y_out, carry_out, borrow_out, zero, negative, overflow, parity, illegal_op
  );
endinterface

// File: rtl/alu_seq_param.sv
// Handshaked multi-cycle ALU of parametrised width: single-cycle arithmetic/logic,
// bit-serial shifts and rotates, result and flags held until acknowledged.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  alu_seq_param_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_CADD = 5'd1,  OP_SUB   = 5'd2,  OP_BSUB  = 5'd3;
  localparam logic [4:0] OP_NEG  = 5'd4,  OP_INC  = 5'd5,  OP_DEC   = 5'd6,  OP_PASS  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR   = 5'd10, OP_COMP  = 5'd11;
  localparam logic [4:0] OP_LASH = 5'd12, OP_RASH = 5'd13, OP_LLSH  = 5'd14, OP_RLSH  = 5'd15;
  localparam logic [4:0] OP_LROT = 5'd16, OP_RROT = 5'd17, OP_LCROT = 5'd18, OP_RCROT = 5'd19;

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [1:0]         state_r;
  logic [4:0]         op_r;
  logic [WIDTH-1:0]   data_r;
  logic               cbit_r;
  logic               ovf_r;
  logic [SHAMT_W-1:0] cnt_r;

  logic               accept_s;
  logic               is_shift_s;
  logic               is_crot_s;
  logic [SHAMT_W-1:0] k_s;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   rhs_s;
  logic [WIDTH:0]     wide_s;
  logic [WIDTH-1:0]   alu_y_s;
  logic               alu_c_s, alu_b_s, alu_v_s, alu_ill_s;
  logic [WIDTH-1:0]   step_data_s;
  logic               step_c_s, step_v_s;

  assign a_s        = bus.operand_A;
  assign k_s        = bus.operand_B[SHAMT_W-1:0];
  assign accept_s   = (state_r == S_IDLE) && bus.enable && bus.input_ready;
  assign is_shift_s = (bus.opcode >= OP_LASH) && (bus.opcode <= OP_RCROT);
  assign is_crot_s  = (bus.opcode == OP_LCROT) || (bus.opcode == OP_RCROT);
  assign bus.busy         = (state_r != S_IDLE);
  assign bus.result_ready = (state_r == S_DONE);

  // Single-cycle result for the accepted opcode; shift opcodes here cover only k == 0.
  always_comb begin
    alu_y_s   = '0;
    alu_c_s   = 1'b0;
    alu_b_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_ill_s = 1'b0;
    rhs_s     = bus.operand_B;
    wide_s    = '0;
    case (bus.opcode)
      OP_ADD, OP_CADD, OP_INC: begin
        rhs_s   = (bus.opcode == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.operand_B;
        wide_s  = {1'b0, a_s} + {1'b0, rhs_s}
                + {{WIDTH{1'b0}}, ((bus.opcode == OP_CADD) ? bus.carry_in : 1'b0)};
        alu_y_s = wide_s[MSB:0];
        alu_c_s = wide_s[WIDTH];
        alu_v_s = (a_s[MSB] == rhs_s[MSB]) && (alu_y_s[MSB] != a_s[MSB]);
      end
      OP_SUB, OP_BSUB, OP_DEC: begin
        rhs_s   = (bus.opcode == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.operand_B;
        wide_s  = {1'b0, a_s} - {1'b0, rhs_s}
                - {{WIDTH{1'b0}}, ((bus.opcode == OP_BSUB) ? bus.borrow_in : 1'b0)};
        alu_y_s = wide_s[MSB:0];
        alu_b_s = wide_s[WIDTH];
        alu_v_s = (a_s[MSB] != rhs_s[MSB]) && (alu_y_s[MSB] != a_s[MSB]);
      end
      OP_NEG: begin
        alu_y_s = {WIDTH{1'b0}} - a_s;
        alu_b_s = |a_s;
        alu_v_s = (a_s == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_PASS: alu_y_s = a_s;
      OP_AND:  alu_y_s = a_s & bus.operand_B;
      OP_OR:   alu_y_s = a_s | bus.operand_B;
      OP_XOR:  alu_y_s = a_s ^ bus.operand_B;
      OP_COMP: alu_y_s = ~a_s;
      OP_LASH, OP_RASH, OP_LLSH, OP_RLSH, OP_LROT, OP_RROT, OP_LCROT, OP_RCROT: begin
        alu_y_s = a_s;
        alu_c_s = is_crot_s ? bus.carry_in : 1'b0;
      end
      default: alu_ill_s = 1'b1;
    endcase
  end

  // One bit of shift/rotate on the latched data; cbit_r is the bit last moved out (or the carry ring bit).
  always_comb begin
    step_data_s = data_r;
    step_c_s    = cbit_r;
    step_v_s    = ovf_r;
    case (op_r)
      OP_LASH: begin
        step_data_s = {data_r[MSB-1:0], 1'b0};
        step_c_s    = data_r[MSB];
        step_v_s    = ovf_r | (data_r[MSB] ^ data_r[MSB-1]);
      end
      OP_LLSH: begin
        step_data_s = {data_r[MSB-1:0], 1'b0};
        step_c_s    = data_r[MSB];
      end
      OP_RASH: begin
        step_data_s = {data_r[MSB], data_r[MSB:1]};
        step_c_s    = data_r[0];
      end
      OP_RLSH: begin
        step_data_s = {1'b0, data_r[MSB:1]};
        step_c_s    = data_r[0];
      end
      OP_LROT: begin
        step_data_s = {data_r[MSB-1:0], data_r[MSB]};
        step_c_s    = data_r[MSB];
      end
      OP_RROT: begin
        step_data_s = {data_r[0], data_r[MSB:1]};
        step_c_s    = data_r[0];
      end
      OP_LCROT: begin
        step_data_s = {data_r[MSB-1:0], cbit_r};
        step_c_s    = data_r[MSB];
      end
      OP_RCROT: begin
        step_data_s = {cbit_r, data_r[MSB:1]};
        step_c_s    = data_r[0];
      end
      default: begin
        step_data_s = data_r;
        step_c_s    = cbit_r;
        step_v_s    = ovf_r;
      end
    endcase
  end

  // FSM, shift datapath and the held result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      op_r           <= 5'd0;
      data_r         <= '0;
      cbit_r         <= 1'b0;
      ovf_r          <= 1'b0;
      cnt_r          <= '0;
      bus.y_out      <= '0;
      bus.carry_out  <= 1'b0;
      bus.borrow_out <= 1'b0;
      bus.zero       <= 1'b0;
      bus.negative   <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.parity     <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r <= bus.opcode;
            if (is_shift_s && (k_s != '0)) begin
              state_r        <= S_SHIFT;
              data_r         <= a_s;
              cbit_r         <= is_crot_s ? bus.carry_in : 1'b0;
              ovf_r          <= 1'b0;
              cnt_r          <= k_s;
              bus.illegal_op <= 1'b0;
            end else begin
              state_r        <= S_DONE;
              bus.y_out      <= alu_y_s;
              bus.carry_out  <= alu_c_s;
              bus.borrow_out <= alu_b_s;
              bus.zero       <= (alu_y_s == '0);
              bus.negative   <= alu_y_s[MSB];
              bus.overflow   <= alu_v_s;
              bus.parity     <= odd_parity(alu_y_s);
              bus.illegal_op <= alu_ill_s;
            end
          end
        end
        S_SHIFT: begin
          if (bus.enable) begin
            data_r <= step_data_s;
            cbit_r <= step_c_s;
            ovf_r  <= step_v_s;
            cnt_r  <= cnt_r - SHAMT_W'(1);
            // Last step: publish the shifted value together with its flags.
            if (cnt_r == SHAMT_W'(1)) begin
              state_r        <= S_DONE;
              bus.y_out      <= step_data_s;
              bus.carry_out  <= step_c_s;
              bus.borrow_out <= 1'b0;
              bus.zero       <= (step_data_s == '0);
              bus.negative   <= step_data_s[MSB];
              bus.overflow   <= step_v_s;
              bus.parity     <= odd_parity(step_data_s);
              bus.illegal_op <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.result_ack) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end
endmodule
